// File: rtl/p24_spi_master_if.sv
// Memory-mapped request/response bus between the CPU and the p24 SPI master.
interface p24_spi_master_if;
  logic        valid;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input rdata, input ready);
  modport slave  (input valid, input addr, input wdata, input wstrb,
                  output rdata, output ready);
endinterface

// File: rtl/p24_spi_master.sv
// SPI master with run-time CPOL/CPHA, bit order, 1-4 byte transfers and a
// programmable half-period divider; DATA writes block until the frame is done.
module p24_spi_master #(
  parameter int          NUM_CS     = 2,
  parameter logic [15:0] DIV_RESET  = 16'd2,
  parameter logic        CPOL_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  p24_spi_master_if.slave   bus,
  output logic [NUM_CS-1:0] cen,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_TRAIL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CS-1:0] cs_en_q, cs_en_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [1:0]        len_q, len_d;
  logic              lsb_q, lsb_d;
  logic [15:0]       div_q, div_d;
  logic [31:0]       rx_q, rx_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [15:0]       tick_q, tick_d;
  logic [15:0]       h_q, h_d;
  logic              samp_q, samp_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        acc_s, wr_s, launch_s, tick_end_s, in_bit_s;
  logic        out_cur_s, out_nxt_s, first_s;
  logic [4:0]  msb_idx_s;
  logic [5:0]  nbits_s;
  logic [31:0] mask_s, load_s, shifted_s, ctrl_rd_s;

  assign acc_s      = bus.valid && !ready_q && (state_q == ST_IDLE);
  assign wr_s       = |bus.wstrb;
  assign launch_s   = acc_s && wr_s && (bus.addr == 2'd1);
  assign tick_end_s = (tick_q == (h_q - 16'd1));
  assign msb_idx_s  = {len_q, 3'b111};
  assign nbits_s    = {1'b0, len_q, 3'b000} + 6'd8;
  // CPHA=1 samples on the trailing edge, so the live pin feeds the shift directly.
  assign in_bit_s   = cpha_q ? miso : samp_q;

  // Bit-length mask for the current transfer length.
  always_comb begin
    case (len_q)
      2'd0:    mask_s = 32'h0000_00FF;
      2'd1:    mask_s = 32'h0000_FFFF;
      2'd2:    mask_s = 32'h00FF_FFFF;
      default: mask_s = 32'hFFFF_FFFF;
    endcase
  end

  // Shift-register views: load value, shifted value and the bit on the wire.
  always_comb begin
    load_s    = bus.wdata & mask_s;
    shifted_s = lsb_q ? ((shreg_q >> 1) | ({31'd0, in_bit_s} << msb_idx_s))
                      : (((shreg_q << 1) | {31'd0, in_bit_s}) & mask_s);
    out_cur_s = lsb_q ? shreg_q[0] : shreg_q[msb_idx_s];
    out_nxt_s = lsb_q ? shifted_s[0] : shifted_s[msb_idx_s];
    first_s   = lsb_q ? load_s[0] : load_s[msb_idx_s];
  end

  // CTRL readback image.
  always_comb begin
    ctrl_rd_s               = 32'd0;
    ctrl_rd_s[NUM_CS-1:0]   = cs_en_q;
    ctrl_rd_s[8]            = cpol_q;
    ctrl_rd_s[9]            = cpha_q;
    ctrl_rd_s[11:10]        = len_q;
    ctrl_rd_s[12]           = lsb_q;
    ctrl_rd_s[31]           = (state_q != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cs_en_q <= {NUM_CS{1'b0}};
      cpol_q  <= CPOL_RESET;
      cpha_q  <= 1'b0;
      len_q   <= 2'd0;
      lsb_q   <= 1'b0;
      div_q   <= DIV_RESET;
      rx_q    <= 32'd0;
      shreg_q <= 32'd0;
      cnt_q   <= 6'd0;
      tick_q  <= 16'd0;
      h_q     <= 16'd1;
      samp_q  <= 1'b0;
      sclk_q  <= CPOL_RESET;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cs_en_q <= cs_en_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      len_q   <= len_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      rx_q    <= rx_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      samp_q  <= samp_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; DONE lasts two cycles so ready lands at 2*N*H+2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = launch_s ? ST_LEAD : ST_IDLE;
      ST_LEAD:  state_d = tick_end_s ? ST_TRAIL : ST_LEAD;
      ST_TRAIL: state_d = tick_end_s ? ((cnt_q == 6'd1) ? ST_DONE : ST_LEAD) : ST_TRAIL;
      ST_DONE:  state_d = (tick_q == 16'd1) ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register writes, read mux and per-phase SPI actions.
  always_comb begin
    cs_en_d = cs_en_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    len_d   = len_q;
    lsb_d   = lsb_q;
    div_d   = div_q;
    rx_d    = rx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    h_d     = h_q;
    samp_d  = samp_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = 1'b0;
    rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol_q;
        tick_d = 16'd0;
        if (acc_s) begin
          ready_d = ~launch_s;
          if (wr_s) begin
            case (bus.addr)
              2'd0: begin
                cs_en_d = bus.wdata[NUM_CS-1:0];
                cpol_d  = bus.wdata[8];
                cpha_d  = bus.wdata[9];
                len_d   = bus.wdata[11:10];
                lsb_d   = bus.wdata[12];
              end
              2'd1: begin
                shreg_d = load_s;
                cnt_d   = nbits_s;
                h_d     = (div_q == 16'd0) ? 16'd1 : div_q;
                mosi_d  = cpha_q ? mosi_q : first_s;
              end
              2'd2:    div_d   = bus.wdata[15:0];
              default: rdata_d = 32'd0;
            endcase
          end else begin
            case (bus.addr)
              2'd0:    rdata_d = ctrl_rd_s;
              2'd1:    rdata_d = rx_q;
              2'd2:    rdata_d = {16'd0, div_q};
              default: rdata_d = 32'd0;
            endcase
          end
        end else begin
          ready_d = 1'b0;
        end
      end
      ST_LEAD: begin
        tick_d = tick_end_s ? 16'd0 : (tick_q + 16'd1);
        if (tick_end_s) begin
          sclk_d = ~cpol_q;
          samp_d = cpha_q ? samp_q : miso;
          mosi_d = cpha_q ? out_cur_s : mosi_q;
        end else begin
          sclk_d = sclk_q;
        end
      end
      ST_TRAIL: begin
        tick_d = tick_end_s ? 16'd0 : (tick_q + 16'd1);
        if (tick_end_s) begin
          sclk_d  = cpol_q;
          shreg_d = shifted_s;
          cnt_d   = cnt_q - 6'd1;
          // The final shift only completes rx; mosi keeps the last bit sent.
          mosi_d  = (!cpha_q && (cnt_q != 6'd1)) ? out_nxt_s : mosi_q;
        end else begin
          sclk_d = sclk_q;
        end
      end
      ST_DONE: begin
        tick_d = tick_q + 16'd1;
        if (tick_q == 16'd1) begin
          rx_d    = shreg_q;
          ready_d = 1'b1;
          rdata_d = shreg_q;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: ready_d = 1'b0;
    endcase
  end

  assign cen       = ~cs_en_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

endmodule
